// File: rtl/fetch_queue_if.sv
// fetch_queue handshake bundle: imem request/response, decode hand-off, redirect.
// master = fetch_queue side, slave = memory/decode/branch side.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_req_addr;
  logic          imem_resp_valid;
  logic [31:0]   imem_resp_data;
  logic          id_valid;
  logic          id_ready;
  logic [31:0]   id_instruction;
  logic [31:0]   id_pc;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] count;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    output id_valid,
    output id_instruction,
    output id_pc,
    output count,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  id_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    input  id_valid,
    input  id_instruction,
    input  id_pc,
    input  count,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output id_ready,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue with credit-based fetch and redirect flush.
// Optional same-cycle response-to-decode bypass: define FETCHQ_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.master fq
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      mem_q [DEPTH];
  entry_t      head;
  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic [2:0]  outstanding;
  logic [2:0]  outstanding_nxt;
  logic [2:0]  discard;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic [31:0] inflight;
  logic        credit;
  logic        req_fire;
  logic        resp_live;
  logic        head_valid;
  logic        push;
  logic        pop_fifo;

  assign count      = wr_ptr - rd_ptr;
  assign head_valid = (count != '0);
  assign head       = mem_q[rd_ptr[AW-1:0]];

  // Every non-discarded outstanding request owns a FIFO slot.
  assign inflight = 32'(count)
                  + 32'(outstanding)
                  - 32'(discard);
  assign credit   = (outstanding < 3'(MAX_OUTSTANDING))
                 && (inflight < 32'(DEPTH));

  assign fq.imem_req_valid = reset
                          && !fq.redirect_valid
                          && credit;
  assign fq.imem_req_addr  = fetch_pc;
  assign fq.count          = count;

  assign req_fire  = fq.imem_req_valid && fq.imem_req_ready;
  assign resp_live = fq.imem_resp_valid
                  && (discard == 3'd0)
                  && !fq.redirect_valid;
  assign pop_fifo  = head_valid && fq.id_ready;

`ifdef FETCHQ_BYPASS_EN
  logic byp;

  assign byp         = !head_valid && resp_live;
  assign fq.id_valid = head_valid || byp;
  assign push        = resp_live && !(byp && fq.id_ready);

  always_comb begin
    fq.id_instruction = 32'h0;
    fq.id_pc          = 32'h0;
    unique case (1'b1)
      head_valid: begin
        fq.id_instruction = head.instr;
        fq.id_pc          = head.pc;
      end
      byp: begin
        fq.id_instruction = fq.imem_resp_data;
        fq.id_pc          = resp_pc;
      end
      default: ;
    endcase
  end
`else
  assign fq.id_valid       = head_valid;
  assign push              = resp_live;
  assign fq.id_instruction = head_valid ? head.instr : 32'h0;
  assign fq.id_pc          = head_valid ? head.pc : 32'h0;
`endif

  assign outstanding_nxt = outstanding
                         + {2'b00, req_fire}
                         - {2'b00, fq.imem_resp_valid};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= 3'd0;
      discard     <= 3'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (fq.redirect_valid) begin
        // Whatever is still in flight after this cycle is stale.
        fetch_pc <= fq.redirect_pc;
        resp_pc  <= fq.redirect_pc;
        discard  <= outstanding_nxt;
        rd_ptr   <= wr_ptr;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + 32'd4;
        if (fq.imem_resp_valid && (discard != 3'd0))
          discard <= discard - 3'd1;
        if (resp_live)
          resp_pc <= resp_pc + 32'd4;
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop_fifo)
          rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr[AW-1:0]] <= '{pc: resp_pc, instr: fq.imem_resp_data};
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between instruction memory and the IF/ID pipeline register of the pipelined CPU. Issues sequential word fetches to a variable-latency, in-order instruction memory. Buffers returned instructions with their PCs in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake. A branch redirect flushes the queue and discards in-flight responses.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; 1..7
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low; one clock domain, async reset active-low
- imem_req_valid  output  1  request to instruction memory
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  32  word address of request (fetch_pc)
- imem_resp_valid  input  1  response beat; no ready, always accepted; responses in request order
- imem_resp_data  input  32  instruction word
- id_valid  output  1  instruction available to decode
- id_ready  input  1  decode accepts this cycle
- id_instruction  output  32  head instruction
- id_pc  output  32  PC of head instruction
- redirect_valid  input  1  taken branch; flush and refetch
- redirect_pc  input  32  redirect target, word aligned
- count  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- State: fetch_pc, resp_pc, outstanding (3 b), discard (3 b), FIFO storage {pc, instr}, wr_ptr/rd_ptr with extra wrap bit.
- Credit: imem_req_valid = !redirect_valid && outstanding < MAX_OUTSTANDING && (count + outstanding − discard) < DEPTH. Space is reserved for every non-discarded outstanding request, so a response never finds the FIFO full.
- Request accept (valid && ready): fetch_pc += 4 (mod 2^32), outstanding += 1.
- Response: outstanding −= 1. If discard > 0, discard −= 1 and the data is dropped. Otherwise push {resp_pc, imem_resp_data} and resp_pc += 4.
- Pop: id_valid && id_ready. rd_ptr advances. id_valid = (count != 0); id_instruction/id_pc come from the head entry.
- Accept, response and pop in the same cycle are independent; count_next = count + push − pop.
- Redirect (highest priority):
  - fetch_pc and resp_pc load redirect_pc; FIFO empties (count → 0).
  - discard loads outstanding_next, which already excludes any response arriving this cycle. That response is dropped regardless of discard.
  - No request is issued in the redirect cycle.
  - A pop handshake in the redirect cycle counts as transferred; decode squashes it.
- Reset: fetch_pc = resp_pc = RESET_PC; outstanding = discard = 0; FIFO empty.
  - Output reset values: imem_req_valid 0 while reset is asserted, imem_req_addr RESET_PC, id_valid 0, count 0, id_instruction 0, id_pc 0.
  - Responses to requests issued before reset are the memory's responsibility; the memory is reset together with this block.

## Timing
- imem_req_valid and imem_req_addr depend on registers plus redirect_valid only; no dependence on imem_req_ready.
- Without bypass, a response pushed in cycle N shows id_valid=1 in cycle N+1.
- Peak throughput is one instruction per cycle when memory latency ≤ MAX_OUTSTANDING cycles and decode never stalls.
- Redirect in cycle N: first request to redirect_pc is issued in cycle N+1.
- Full queue: imem_req_valid stays low until a pop frees credit; the request is re-raised the cycle after the pop.

## Configuration
- FETCHQ_BYPASS_EN defined: when count == 0 and a non-discarded response arrives with no redirect, id_valid=1 in the same cycle, with id_instruction = imem_resp_data and id_pc = resp_pc.
  - If id_ready is also high, the entry is consumed without being written.
  - Otherwise it is written and presented normally next cycle.
  - This adds a combinational path from imem_resp to id.
- Undefined: id outputs are driven from FIFO storage only; one cycle minimum response-to-decode latency.

## Test plan
- Reset release with RESET_PC=0, 1-cycle memory, id_ready=1 -> id_pc sequence 0x0,0x4,0x8,… one per cycle after fill; count ≤ 2.
- id_ready=0, DEPTH=4 -> exactly 4 requests accepted (0x0..0xC); imem_req_valid low; count=4. Raise id_ready for 1 cycle -> next request 0x10.
- Two requests outstanding (0x8, 0xC), redirect_pc=0x100 -> both responses dropped; next id_pc=0x100 with instruction from 0x100; no 0x8/0xC delivered.
- Redirect in the same cycle as a response with one more outstanding -> discard=1; both old responses dropped; count=0 the next cycle.
- Reset asserted mid-stream with count=3 -> outputs immediately return to reset values; after release, the first request address is RESET_PC.
- FETCHQ_BYPASS_EN, empty queue, response 0xDEADBEEF at resp_pc 0x20, id_ready=1 -> id_valid=1 with id_instruction 0xDEADBEEF and id_pc 0x20 in the same cycle; count stays 0.
